// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
// Purpose : bundles every decode-side, forwarding-side and stage-output signal
//           of the ID/EX pipeline register so the stage and its environment
//           connect through one port.
// Modports:
//   slave  - the ID/EX stage itself: consumes decode fields, register-file
//            read data, EX/MEM/WB forwarding candidates, stall_in and flush;
//            produces the registered EX-side fields and stall_req.
//   master - the surrounding pipeline (or a testbench): the mirror image.
// -----------------------------------------------------------------------------
interface id_ex_stage_if;
   // decode side
   logic [3:0]  Read_Reg_1;
   logic [3:0]  Read_Reg_2;
   logic [15:0] Read_Bus_1;
   logic [15:0] Read_Bus_2;
   logic [3:0]  Dst_Reg_in;
   logic        RegWrite_in;
   logic        MemRead_in;
   logic        MemWrite_in;
   logic        valid_in;
   logic [3:0]  ALU_Op_in;
   logic [15:0] Imm_in;
   // forwarding candidates
   logic [15:0] EX_Result;
   logic        MEM_RegWrite;
   logic [3:0]  MEM_Write_Reg;
   logic [15:0] MEM_Result;
   logic        WB_RegWrite;
   logic [3:0]  WB_Write_Reg;
   logic [15:0] WB_Write_Bus;
   // pipeline control
   logic        stall_in;
   logic        flush;
   // stage outputs
   logic [15:0] Op_A;
   logic [15:0] Op_B;
   logic [15:0] Imm_out;
   logic [3:0]  Dst_Reg_out;
   logic [3:0]  ALU_Op_out;
   logic        RegWrite_out;
   logic        MemRead_out;
   logic        MemWrite_out;
   logic        valid_out;
   logic        stall_req;

   modport slave (
      input  Read_Reg_1, Read_Reg_2, Read_Bus_1, Read_Bus_2,
      input  Dst_Reg_in, RegWrite_in, MemRead_in, MemWrite_in, valid_in,
      input  ALU_Op_in, Imm_in,
      input  EX_Result, MEM_RegWrite, MEM_Write_Reg, MEM_Result,
      input  WB_RegWrite, WB_Write_Reg, WB_Write_Bus,
      input  stall_in, flush,
      output Op_A, Op_B, Imm_out, Dst_Reg_out, ALU_Op_out,
      output RegWrite_out, MemRead_out, MemWrite_out, valid_out, stall_req
   );

   modport master (
      output Read_Reg_1, Read_Reg_2, Read_Bus_1, Read_Bus_2,
      output Dst_Reg_in, RegWrite_in, MemRead_in, MemWrite_in, valid_in,
      output ALU_Op_in, Imm_in,
      output EX_Result, MEM_RegWrite, MEM_Write_Reg, MEM_Result,
      output WB_RegWrite, WB_Write_Reg, WB_Write_Bus,
      output stall_in, flush,
      input  Op_A, Op_B, Imm_out, Dst_Reg_out, ALU_Op_out,
      input  RegWrite_out, MemRead_out, MemWrite_out, valid_out, stall_req
   );
endinterface

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// Purpose : ID/EX pipeline register with operand forwarding (EX > MEM > WB >
//           register file) and load-use hazard detection. One-cycle latency,
//           one instruction per cycle when not stalled.
// Ports   :
//   clk    - single clock, all state updates on the rising edge
//   rst_n  - synchronous active-low reset
//   io_bus - id_ex_stage_if.slave: decode fields, register-file read data,
//            forwarding candidates, stall_in/flush in; registered stage
//            outputs and combinational stall_req out.
// -----------------------------------------------------------------------------
module id_ex_stage (
   input  logic          clk,
   input  logic          rst_n,
   id_ex_stage_if.slave  io_bus
);

   // registered stage state
   logic [15:0] r_op_a;
   logic [15:0] r_op_b;
   logic [15:0] r_imm;
   logic [3:0]  r_dst;
   logic [3:0]  r_alu_op;
   logic        r_reg_write;
   logic        r_mem_read;
   logic        r_mem_write;
   logic        r_valid;

   logic        w_ex_fwd_ok;
   logic        w_hazard;
   logic [15:0] w_op_a;
   logic [15:0] w_op_b;

   // Operand selection by priority. The EX candidate is only usable when the
   // held instruction is not a load (its result is not ready yet).
   function automatic logic [15:0] resolve_operand(
      input logic [3:0]  rd_reg,
      input logic [15:0] rd_bus,
      input logic        ex_ok,
      input logic [3:0]  ex_reg,
      input logic [15:0] ex_val,
      input logic        mem_we,
      input logic [3:0]  mem_reg,
      input logic [15:0] mem_val,
      input logic        wb_we,
      input logic [3:0]  wb_reg,
      input logic [15:0] wb_val
   );
      logic [15:0] v;
      if (ex_ok && (ex_reg == rd_reg)) begin
         v = ex_val;
      end else if (mem_we && (mem_reg == rd_reg)) begin
         v = mem_val;
      end else if (wb_we && (wb_reg == rd_reg)) begin
         // same-edge register-file write is not visible on Read_Bus yet
         v = wb_val;
      end else begin
         v = rd_bus;
      end
      return v;
   endfunction

   // Hazard detection and forwarding muxes from current registered state.
   always_comb begin
      w_ex_fwd_ok = r_valid & r_reg_write & ~r_mem_read;
      w_hazard    = r_valid & r_mem_read & r_reg_write & io_bus.valid_in &
                    ((r_dst == io_bus.Read_Reg_1) | (r_dst == io_bus.Read_Reg_2));
      w_op_a = resolve_operand(io_bus.Read_Reg_1, io_bus.Read_Bus_1,
                               w_ex_fwd_ok, r_dst, io_bus.EX_Result,
                               io_bus.MEM_RegWrite, io_bus.MEM_Write_Reg, io_bus.MEM_Result,
                               io_bus.WB_RegWrite, io_bus.WB_Write_Reg, io_bus.WB_Write_Bus);
      w_op_b = resolve_operand(io_bus.Read_Reg_2, io_bus.Read_Bus_2,
                               w_ex_fwd_ok, r_dst, io_bus.EX_Result,
                               io_bus.MEM_RegWrite, io_bus.MEM_Write_Reg, io_bus.MEM_Result,
                               io_bus.WB_RegWrite, io_bus.WB_Write_Reg, io_bus.WB_Write_Bus);
   end

   // Stage register: reset > flush > hold > hazard bubble > capture.
   always_ff @(posedge clk) begin
      if (!rst_n || io_bus.flush || (!io_bus.stall_in && w_hazard)) begin
         r_op_a      <= 16'h0000;
         r_op_b      <= 16'h0000;
         r_imm       <= 16'h0000;
         r_dst       <= 4'h0;
         r_alu_op    <= 4'h0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_valid     <= 1'b0;
      end else if (io_bus.stall_in) begin
         r_op_a      <= r_op_a;
         r_op_b      <= r_op_b;
         r_imm       <= r_imm;
         r_dst       <= r_dst;
         r_alu_op    <= r_alu_op;
         r_reg_write <= r_reg_write;
         r_mem_read  <= r_mem_read;
         r_mem_write <= r_mem_write;
         r_valid     <= r_valid;
      end else begin
         r_op_a      <= w_op_a;
         r_op_b      <= w_op_b;
         r_imm       <= io_bus.Imm_in;
         r_dst       <= io_bus.Dst_Reg_in;
         r_alu_op    <= io_bus.ALU_Op_in;
         // an invalid slot must never write or touch memory downstream
         r_reg_write <= io_bus.RegWrite_in & io_bus.valid_in;
         r_mem_read  <= io_bus.MemRead_in  & io_bus.valid_in;
         r_mem_write <= io_bus.MemWrite_in & io_bus.valid_in;
         r_valid     <= io_bus.valid_in;
      end
   end

   // Outputs come straight from the stage registers; stall_req is combinational.
   assign io_bus.Op_A         = r_op_a;
   assign io_bus.Op_B         = r_op_b;
   assign io_bus.Imm_out      = r_imm;
   assign io_bus.Dst_Reg_out  = r_dst;
   assign io_bus.ALU_Op_out   = r_alu_op;
   assign io_bus.RegWrite_out = r_reg_write;
   assign io_bus.MemRead_out  = r_mem_read;
   assign io_bus.MemWrite_out = r_mem_write;
   assign io_bus.valid_out    = r_valid;
   assign io_bus.stall_req    = w_hazard | io_bus.stall_in;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Purpose : directed scenarios plus random traffic for id_ex_stage, checked
//           against a behavioural model of the stage.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   id_ex_stage_if bus ();

   id_ex_stage dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model state: what the stage should currently be presenting
   logic [15:0] m_op_a, m_op_b, m_imm;
   logic [3:0]  m_dst, m_alu;
   logic        m_rw, m_mr, m_mw, m_v;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Model: a write-back source wins if it is the first enabled, matching
   // entry in the producer list ordered youngest first.
   function automatic logic [15:0] model_read(input logic [3:0] r, input logic [15:0] rf);
      logic        en  [3];
      logic [3:0]  rg  [3];
      logic [15:0] val [3];
      en[0] = m_v && m_rw && !m_mr;    rg[0] = m_dst;             val[0] = bus.EX_Result;
      en[1] = bus.MEM_RegWrite;        rg[1] = bus.MEM_Write_Reg; val[1] = bus.MEM_Result;
      en[2] = bus.WB_RegWrite;         rg[2] = bus.WB_Write_Reg;  val[2] = bus.WB_Write_Bus;
      for (int k = 0; k < 3; k++) begin
         if (en[k] && rg[k] == r) return val[k];
      end
      return rf;
   endfunction

   function automatic logic model_load_use();
      logic load_held;
      load_held = m_v && m_mr && m_rw;
      return load_held && bus.valid_in &&
             (m_dst == bus.Read_Reg_1 || m_dst == bus.Read_Reg_2);
   endfunction

   task automatic clear_in();
      rst_n = 1'b1;
      bus.Read_Reg_1 = 4'h0;   bus.Read_Reg_2 = 4'h0;
      bus.Read_Bus_1 = 16'h0;  bus.Read_Bus_2 = 16'h0;
      bus.Dst_Reg_in = 4'h0;   bus.RegWrite_in = 1'b0;
      bus.MemRead_in = 1'b0;   bus.MemWrite_in = 1'b0;
      bus.valid_in = 1'b0;     bus.ALU_Op_in = 4'h0;  bus.Imm_in = 16'h0;
      bus.EX_Result = 16'h0;   bus.MEM_RegWrite = 1'b0;
      bus.MEM_Write_Reg = 4'h0; bus.MEM_Result = 16'h0;
      bus.WB_RegWrite = 1'b0;  bus.WB_Write_Reg = 4'h0; bus.WB_Write_Bus = 16'h0;
      bus.stall_in = 1'b0;     bus.flush = 1'b0;
   endtask

   // One cycle: inputs already applied while clk is low.
   task automatic step();
      logic [15:0] n_a, n_b, n_i;
      logic [3:0]  n_d, n_al;
      logic        n_rw, n_mr, n_mw, n_v, hz;
      #1;
      hz = model_load_use();
      chk("stall_req", {31'd0, bus.stall_req}, {31'd0, hz | bus.stall_in});
      n_a = m_op_a; n_b = m_op_b; n_i = m_imm; n_d = m_dst; n_al = m_alu;
      n_rw = m_rw;  n_mr = m_mr;  n_mw = m_mw; n_v = m_v;
      if (!rst_n || bus.flush || (hz && !bus.stall_in)) begin
         {n_a, n_b, n_i, n_d, n_al, n_rw, n_mr, n_mw, n_v} = '0;
      end else if (!bus.stall_in) begin
         n_a  = model_read(bus.Read_Reg_1, bus.Read_Bus_1);
         n_b  = model_read(bus.Read_Reg_2, bus.Read_Bus_2);
         n_i  = bus.Imm_in; n_d = bus.Dst_Reg_in; n_al = bus.ALU_Op_in;
         n_v  = bus.valid_in;
         n_rw = bus.valid_in ? bus.RegWrite_in : 1'b0;
         n_mr = bus.valid_in ? bus.MemRead_in  : 1'b0;
         n_mw = bus.valid_in ? bus.MemWrite_in : 1'b0;
      end
      @(posedge clk);
      #1;
      m_op_a = n_a; m_op_b = n_b; m_imm = n_i; m_dst = n_d; m_alu = n_al;
      m_rw = n_rw;  m_mr = n_mr;  m_mw = n_mw; m_v = n_v;
      chk("Op_A", {16'd0, bus.Op_A}, {16'd0, m_op_a});
      chk("Op_B", {16'd0, bus.Op_B}, {16'd0, m_op_b});
      chk("Imm_out", {16'd0, bus.Imm_out}, {16'd0, m_imm});
      chk("ctrl", {20'd0, bus.Dst_Reg_out, bus.ALU_Op_out, bus.RegWrite_out,
                   bus.MemRead_out, bus.MemWrite_out, bus.valid_out},
                  {20'd0, m_dst, m_alu, m_rw, m_mr, m_mw, m_v});
      @(negedge clk);
   endtask

   task automatic load_to(input logic [3:0] r);
      clear_in();
      bus.valid_in = 1'b1; bus.RegWrite_in = 1'b1; bus.MemRead_in = 1'b1;
      bus.Dst_Reg_in = r;
      step();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      {m_op_a, m_op_b, m_imm, m_dst, m_alu, m_rw, m_mr, m_mw, m_v} = '0;
      clear_in();
      rst_n = 1'b0;
      @(negedge clk);
      step();
      step();
      chk("reset_valid", {31'd0, bus.valid_out}, 32'd0);

      // WB write to R3 lands same edge as the read
      clear_in();
      bus.valid_in = 1'b1; bus.Read_Reg_1 = 4'd3; bus.Read_Bus_1 = 16'h1111;
      bus.WB_RegWrite = 1'b1; bus.WB_Write_Reg = 4'd3; bus.WB_Write_Bus = 16'hBEEF;
      bus.Read_Reg_2 = 4'd9;
      step();
      chk("wb_fwd", {16'd0, bus.Op_A}, 32'h0000BEEF);

      // EX beats MEM
      clear_in();
      bus.valid_in = 1'b1; bus.RegWrite_in = 1'b1; bus.Dst_Reg_in = 4'd5;
      step();
      clear_in();
      bus.valid_in = 1'b1; bus.EX_Result = 16'h0010;
      bus.MEM_RegWrite = 1'b1; bus.MEM_Write_Reg = 4'd5; bus.MEM_Result = 16'h0020;
      bus.Read_Reg_2 = 4'd5; bus.Read_Reg_1 = 4'd8;
      step();
      chk("ex_over_mem", {16'd0, bus.Op_B}, 32'h00000010);

      // load-use: one bubble, then MEM forwarding
      load_to(4'd2);
      clear_in();
      bus.valid_in = 1'b1; bus.Read_Reg_1 = 4'd2; bus.Read_Reg_2 = 4'd7;
      bus.Dst_Reg_in = 4'd6; bus.RegWrite_in = 1'b1;
      #1;
      chk("lu_stall", {31'd0, bus.stall_req}, 32'd1);
      step();
      chk("lu_bubble", {31'd0, bus.valid_out}, 32'd0);
      bus.MEM_RegWrite = 1'b1; bus.MEM_Write_Reg = 4'd2; bus.MEM_Result = 16'h00AA;
      step();
      chk("lu_opa", {16'd0, bus.Op_A}, 32'h000000AA);
      chk("lu_valid", {31'd0, bus.valid_out}, 32'd1);

      // load-use plus flush: single bubble
      load_to(4'd2);
      clear_in();
      bus.valid_in = 1'b1; bus.Read_Reg_1 = 4'd2; bus.flush = 1'b1;
      step();
      chk("fl_bubble", {31'd0, bus.valid_out}, 32'd0);
      bus.flush = 1'b0;
      #1;
      chk("fl_stall_clr", {31'd0, bus.stall_req}, 32'd0);
      step();
      chk("fl_valid", {31'd0, bus.valid_out}, 32'd1);

      // downstream stall for three cycles with changing inputs
      bus.Imm_in = 16'h1234;
      step();
      for (int i = 0; i < 3; i++) begin
         bus.stall_in = 1'b1;
         bus.Imm_in = 16'($urandom);
         bus.Read_Bus_1 = 16'($urandom);
         bus.Dst_Reg_in = 4'($urandom);
         #1;
         chk("hold_stall_req", {31'd0, bus.stall_req}, 32'd1);
         step();
         chk("hold_imm", {16'd0, bus.Imm_out}, 32'h00001234);
      end
      bus.stall_in = 1'b0;
      bus.Imm_in = 16'h5678;
      step();
      chk("resume_imm", {16'd0, bus.Imm_out}, 32'h00005678);

      // reset overrides stall and flush
      clear_in();
      bus.valid_in = 1'b1; bus.RegWrite_in = 1'b1; bus.Imm_in = 16'hFFFF;
      bus.Read_Bus_1 = 16'hAAAA;
      step();
      rst_n = 1'b0; bus.stall_in = 1'b1; bus.flush = 1'b1;
      step();
      chk("rst_valid", {31'd0, bus.valid_out}, 32'd0);
      chk("rst_imm", {16'd0, bus.Imm_out}, 32'd0);

      // random traffic; small register range to provoke matches
      for (int n = 0; n < 400; n++) begin
         rst_n             = ($urandom_range(0, 31) != 0);
         bus.flush         = ($urandom_range(0, 9) == 0);
         bus.stall_in      = ($urandom_range(0, 5) == 0);
         bus.valid_in      = ($urandom_range(0, 5) != 0);
         bus.Read_Reg_1    = 4'($urandom_range(0, 3));
         bus.Read_Reg_2    = 4'($urandom_range(0, 3));
         bus.Read_Bus_1    = 16'($urandom);
         bus.Read_Bus_2    = 16'($urandom);
         bus.Dst_Reg_in    = 4'($urandom_range(0, 3));
         bus.RegWrite_in   = 1'($urandom);
         bus.MemRead_in    = 1'($urandom);
         bus.MemWrite_in   = 1'($urandom);
         bus.ALU_Op_in     = 4'($urandom);
         bus.Imm_in        = 16'($urandom);
         bus.EX_Result     = 16'($urandom);
         bus.MEM_RegWrite  = 1'($urandom);
         bus.MEM_Write_Reg = 4'($urandom_range(0, 3));
         bus.MEM_Result    = 16'($urandom);
         bus.WB_RegWrite   = 1'($urandom);
         bus.WB_Write_Reg  = 4'($urandom_range(0, 3));
         bus.WB_Write_Bus  = 16'($urandom);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
